// File: rtl/t05_huff_decoder.sv
`default_nettype none
// ============================================================================
// Module   : t05_huff_decoder
// Purpose  : Huffman decompression engine. Pulls packed compressed bytes
//            (MSB first), walks the Huffman tree held in an external
//            synchronous SRAM one node per read, and emits one 8-bit
//            character for every leaf reached. Stops after a programmed
//            character count; pad bits left in the final byte are dropped.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, root_idx,
//            total_chars         - decode launch and its parameters
//            in_byte/in_valid/
//            in_ready            - compressed byte stream (valid/ready)
//            node_addr/node_rd/
//            node_data           - tree SRAM port, 1-cycle read latency,
//                                  node_data = {left[8:0], right[8:0]},
//                                  child bit8=1 -> leaf char, 0 -> node idx
//            char_out/char_valid/
//            char_ready          - decoded character stream (valid/ready)
//            busy, done, error   - status
// Revision : 1.0 - initial release
// ============================================================================
module t05_huff_decoder #(
  parameter int CNT_W     = 32,
  parameter int MAX_DEPTH = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       root_idx,
  input  logic [CNT_W-1:0] total_chars,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       node_addr,
  output logic             node_rd,
  input  logic [17:0]      node_data,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int                 DEPTH_W     = (MAX_DEPTH < 2) ? 1 : $clog2(MAX_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] C_MAX_DEPTH = DEPTH_W'(MAX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_RDNODE   = 3'd2,
    S_WAITNODE = 3'd3,
    S_EMIT     = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t             state_q,     state_d;
  logic [7:0]         cur_idx_q,   cur_idx_d;
  logic [7:0]         root_q,      root_d;
  logic [CNT_W-1:0]   total_q,     total_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic [DEPTH_W-1:0] depth_q,     depth_d;
  logic [7:0]         shreg_q,     shreg_d;
  logic [3:0]         bits_left_q, bits_left_d;
  logic [7:0]         char_q,      char_d;

  // Branch taken by the current bit: 1 selects the right child.
  logic [8:0] child;
  assign child = shreg_q[7] ? node_data[8:0] : node_data[17:9];

  logic [CNT_W-1:0] count_inc;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    root_d      = root_q;
    total_d     = total_q;
    count_d     = count_q;
    depth_d     = depth_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    char_d      = char_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          root_d    = root_idx;
          total_d   = total_chars;
          cur_idx_d = root_idx;
          count_d   = '0;
          depth_d   = '0;
          state_d   = (total_chars == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        if (in_valid) begin
          shreg_d     = in_byte;
          bits_left_d = 4'd8;
          state_d     = S_RDNODE;
        end
      end

      S_RDNODE: begin
        state_d = S_WAITNODE;
      end

      S_WAITNODE: begin
        shreg_d     = {shreg_q[6:0], 1'b0};
        bits_left_d = bits_left_q - 4'd1;
        if (child[8]) begin
          char_d    = child[7:0];
          cur_idx_d = root_q;
          depth_d   = '0;
          state_d   = S_EMIT;
        end else if (depth_q == C_MAX_DEPTH) begin
          // Tree walk never reaches a leaf: corrupt or cyclic tree.
          state_d = S_ERR;
        end else begin
          // cur_idx survives a refetch so codes can straddle bytes.
          cur_idx_d = child[7:0];
          depth_d   = depth_q + DEPTH_W'(1);
          state_d   = (bits_left_q == 4'd1) ? S_FETCH : S_RDNODE;
        end
      end

      S_EMIT: begin
        if (char_ready) begin
          count_d = count_inc;
          // Last character: any remaining pad bits are simply dropped.
          if (count_inc == total_q) begin
            state_d = S_DONE;
          end else if (bits_left_q == 4'd0) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_RDNODE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_idx_q   <= '0;
      root_q      <= '0;
      total_q     <= '0;
      count_q     <= '0;
      depth_q     <= '0;
      shreg_q     <= '0;
      bits_left_q <= '0;
      char_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      root_q      <= root_d;
      total_q     <= total_d;
      count_q     <= count_d;
      depth_q     <= depth_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      char_q      <= char_d;
    end
  end

  assign in_ready   = (state_q == S_FETCH);
  assign node_rd    = (state_q == S_RDNODE);
  assign node_addr  = cur_idx_q;
  assign char_out   = char_q;
  assign char_valid = (state_q == S_EMIT);
  assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_t05_huff_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_t05_huff_decoder
// Purpose  : Self-checking bench for t05_huff_decoder. Directed scenarios
//            plus randomised trees/streams checked against a bit-stream
//            tree-walk reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t05_huff_decoder;

  localparam int MAXD = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  root_idx = 8'h00;
  logic [31:0] total_chars = 32'h0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  node_addr;
  logic        node_rd;
  logic [17:0] node_data = 18'h0;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        busy, done, error;

  t05_huff_decoder #(.CNT_W(32), .MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .root_idx(root_idx),
    .total_chars(total_chars), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .node_addr(node_addr), .node_rd(node_rd),
    .node_data(node_data), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [21:0] all_outs;
  assign all_outs = {in_ready, node_rd, node_addr, char_out, char_valid, busy, done, error};

  // Tree SRAM: data appears the cycle after the read strobe.
  logic [17:0] tree [0:255];
  always @(posedge clk) if (node_rd) node_data <= tree[node_addr];

  // Byte stream source and observation state
  logic [7:0] src [0:4095];
  int         src_n = 0, src_ptr = 0;
  logic [7:0] got_q [$];
  int n_acc = 0, n_viol = 0, n_rd = 0, n_irdy = 0, n_cv = 0, n_stall = 0;
  int stall_idx = -1, stall_len = 0, stall_cnt = 0;
  bit rand_mode = 0;
  bit hold_prev = 0;
  logic [7:0] prev_char = 8'h00;

  int checks = 0, errors = 0;

  // Reference model state
  logic [7:0] cand [0:63];
  logic [7:0] exp_q [$];
  int exp_bytes;
  bit exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decides every handshake at the negedge preceding the posedge on which
  // it takes effect; inputs stay put until the next negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (src_ptr < src_n) in_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      else                 in_valid = 1'b0;
      in_byte = (src_ptr < src_n) ? src[src_ptr] : 8'h00;
      if (got_q.size() != stall_idx) stall_cnt = 0;
      if (char_valid && got_q.size() == stall_idx && stall_cnt < stall_len) begin
        char_ready = 1'b0;
        stall_cnt++;
        n_stall++;
      end else begin
        char_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (rst_n) begin
        if (in_valid && in_ready) begin n_acc++; src_ptr++; end
        if (char_valid && char_ready) got_q.push_back(char_out);
        if (char_valid && (node_rd || in_ready)) n_viol++;
        if (hold_prev && (!char_valid || char_out !== prev_char)) n_viol++;
        n_rd   += int'(node_rd);
        n_irdy += int'(in_ready);
        n_cv   += int'(char_valid);
      end
      hold_prev = char_valid && !char_ready;
      prev_char = char_out;
    end
  end

  // Reference: consume the stream bit by bit, walking from the root.
  task automatic model(input int root, input int total);
    int p, idx, depth;
    bit leaf, b;
    logic [8:0] ch;
    exp_q.delete();
    exp_err = 0; p = 0; idx = root; depth = 0;
    for (int n = 0; n < total && !exp_err; n++) begin
      leaf = 0;
      while (!leaf && !exp_err) begin
        b = cand[p / 8][7 - (p % 8)];
        p++;
        ch = b ? tree[idx][8:0] : tree[idx][17:9];
        if (ch[8]) begin exp_q.push_back(ch[7:0]); leaf = 1; end
        else if (depth == MAXD) exp_err = 1;
        else begin idx = int'(ch[7:0]); depth++; end
      end
      idx = root; depth = 0;
    end
    exp_bytes = (p + 7) / 8;
  endtask

  function automatic logic [8:0] mk_child(input int i, input int k, input int base);
    if (i < k - 1 && $urandom_range(0, 1) == 1)
      return {1'b0, 8'(base + $urandom_range(i + 1, k - 1))};
    return {1'b1, 8'($urandom_range(0, 255))};
  endfunction

  task automatic push_byte(input logic [7:0] b);
    src[src_n] = b;
    src_n++;
  endtask

  task automatic abc_tree();
    tree[0] = {9'h141, 9'h001};
    tree[1] = {9'h142, 9'h143};
  endtask

  int g0, a0, v0, rd0, ir0, cv0, st0;
  task automatic snap();
    g0 = got_q.size(); a0 = n_acc; v0 = n_viol; rd0 = n_rd; ir0 = n_irdy; cv0 = n_cv; st0 = n_stall;
  endtask

  task automatic start_dec(input int root, input int total);
    @(negedge clk);
    start = 1'b1; root_idx = 8'(root); total_chars = 32'(total);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int k;
    k = 0;
    while (!(done || error) && k < max) begin @(negedge clk); k++; end
    chk({tag, " finished"}, 32'(done || error), 32'd1);
  endtask

  task automatic run_and_check(input string tag, input int root, input int total,
                               input int nbytes, input bit err_exp);
    snap();
    start_dec(root, total);
    wait_end(tag, 5000);
    chk({tag, " nchars"}, 32'(got_q.size() - g0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got_q.size())
        chk($sformatf("%s char%0d", tag, i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
    chk({tag, " bytes"}, 32'(n_acc - a0), 32'(nbytes));
    chk({tag, " done"}, 32'(done), 32'(!err_exp));
    chk({tag, " error"}, 32'(error), 32'(err_exp));
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " protocol"}, 32'(n_viol - v0), 32'd0);
  endtask

  initial begin
    int k, nrd, base, kn, total;
    for (int i = 0; i < 256; i++) tree[i] = 18'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset outs", 32'(all_outs), 32'd0);
    rst_n = 1'b1;

    // Test 1: A=0 B=10 C=11, byte 0x58 -> A B C A
    abc_tree();
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h41};
    push_byte(8'h58);
    run_and_check("t1", 0, 4, 1, 1'b0);

    // Test 2: codes straddle into a second byte
    exp_q = '{8'h43, 8'h43, 8'h43, 8'h43, 8'h41};
    push_byte(8'hFF); push_byte(8'h00);
    run_and_check("t2", 0, 5, 2, 1'b0);

    // Test 3: 5-cycle stall on the 2nd character
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h41};
    push_byte(8'h58);
    stall_idx = got_q.size() + 1; stall_len = 5;
    run_and_check("t3", 0, 4, 1, 1'b0);
    chk("t3 stall cycles", 32'(n_stall - st0), 32'd5);
    stall_idx = -1;

    // Test 4: total = 0
    snap();
    start_dec(0, 0);
    chk("t4 done", 32'(done), 32'd1);
    chk("t4 busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4 node_rd", 32'(n_rd - rd0), 32'd0);
    chk("t4 in_ready", 32'(n_irdy - ir0), 32'd0);

    // Test 5: self-looping tree -> error after 256 internal steps
    tree[0] = 18'h0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) push_byte(8'h00);
    run_and_check("t5", 0, 3, 32, 1'b1);
    chk("t5 char_valid", 32'(n_cv - cv0), 32'd0);

    // Restart clears error, then reset lands in WAITNODE
    abc_tree();
    push_byte(8'h58);
    start_dec(0, 4);
    chk("t6 error cleared", 32'(error), 32'd0);
    k = 0; nrd = 0;
    while (nrd < 2 && k < 100) begin @(negedge clk); k++; if (node_rd) nrd++; end
    chk("t6 reads seen", 32'(nrd), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6 reset outs", 32'(all_outs), 32'd0);
    @(negedge clk);
    chk("t6 reset held", 32'(all_outs), 32'd0);
    rst_n = 1'b1;
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h41};
    push_byte(8'h58);
    run_and_check("t6 rerun", 0, 4, 1, 1'b0);

    // Randomised trees, streams and handshakes vs reference model
    rand_mode = 1;
    for (int t = 0; t < 25; t++) begin
      base  = $urandom_range(0, 240);
      kn    = $urandom_range(1, 12);
      total = $urandom_range(1, 20);
      for (int i = 0; i < kn; i++) tree[base + i] = {mk_child(i, kn, base), mk_child(i, kn, base)};
      for (int i = 0; i < 64; i++) cand[i] = 8'($urandom_range(0, 255));
      model(base, total);
      for (int i = 0; i < exp_bytes; i++) push_byte(cand[i]);
      run_and_check($sformatf("rnd%0d", t), base, total, exp_bytes, exp_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/t05_huff_decoder.md
Name: t05_huff_decoder

Overview:
- Huffman decompression engine: the decode-side counterpart of the translation/encode path.
- Consumes the packed compressed bitstream one byte at a time, MSB first, as read back over SPI from flash.
- Walks the Huffman tree held in tree SRAM (one node per read) and emits one decoded 8-bit character per leaf reached.
- Stops after a programmed character count; trailing pad bits in the last byte are discarded.

Parameters:
- CNT_W, 32, width of the total-character counter.
- MAX_DEPTH, 255, maximum internal-node steps per character before a tree error is flagged.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a decode. Ignored unless in IDLE, DONE or ERR.
- root_idx  input  8  index of the tree root node; sampled on start.
- total_chars  input  CNT_W  number of characters to decode; sampled on start.
- in_byte  input  8  compressed data byte.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  decoder accepts a byte; transfer occurs when in_valid && in_ready.
- node_addr  output  8  tree node index to read.
- node_rd  output  1  node read strobe; node_data is valid exactly one cycle later.
- node_data  input  18  {left[8:0], right[8:0]}. Child bit8=1 means leaf, char in [7:0]. Child bit8=0 means internal, node index in [7:0].
- char_out  output  8  decoded character.
- char_valid  output  1  char_out valid; held until char_ready.
- char_ready  input  1  downstream accepts char_out.
- busy  output  1  high in every state except IDLE, DONE and ERR.
- done  output  1  high in DONE; cleared by the next start.
- error  output  1  high in ERR; cleared by the next start.

Behaviour:
- Reset: all outputs 0. State IDLE. Internal registers (current node, bit counter, depth, char count, shift register) cleared.
- FSM states: IDLE, FETCH, RDNODE, WAITNODE, EMIT, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Latch root_idx and total_chars; cur_idx = root_idx; count = 0; depth = 0; clear done/error.
  - If total_chars == 0, go to DONE next cycle. Otherwise go to FETCH.
- FETCH: in_ready = 1. On handshake: shift register <= in_byte, bits_left = 8, go to RDNODE.
- RDNODE: node_rd = 1 for exactly one cycle, node_addr = cur_idx; go to WAITNODE.
- WAITNODE:
  - Select child = current bit (shreg[7]) ? right : left.
  - Shift the register left by one; bits_left decrements.
  - Leaf child: char_out <= child[7:0], cur_idx <= root, depth <= 0, go to EMIT.
  - Internal child, depth == MAX_DEPTH: go to ERR.
  - Internal child otherwise: cur_idx <= child[7:0], depth++. If bits_left (after decrement) == 0 go to FETCH, else go to RDNODE.
- EMIT:
  - char_valid = 1; char_out held stable while char_ready is low.
  - On char_ready: count++.
  - If count+1 == total_chars, go to DONE; remaining bits in the byte are discarded.
  - Else if bits_left == 0, go to FETCH; else go to RDNODE.
- Timing: 2 cycles per tree edge, plus at least 1 cycle per EMIT, plus the byte-fetch handshake.
- No node_rd and no in_ready during EMIT stalls, DONE or ERR.
- A code may span byte boundaries; cur_idx is preserved across FETCH.
- Count arithmetic is modulo 2^CNT_W; the comparison is for equality only.
- rst_n low in any state immediately forces the reset values, including mid-EMIT with char_valid high.

Test Plan:
- Setup: node0 = {0x141 ('A' leaf), 0x001}; node1 = {0x142 ('B'), 0x143 ('C')}; root=0, so A=0, B=10, C=11. Stimulus: total=4, byte 0x58. Required: chars 0x41, 0x42, 0x43, 0x41; exactly 1 byte accepted; done=1, busy=0.
- Same tree, total=5, bytes 0xFF then 0x00. Required: C, C, C, C, A; exactly 2 bytes accepted; the A code comes from the second byte.
- Backpressure: char_ready held low 5 cycles on the 2nd character of test 1. Required: char_out stays 0x42 with char_valid high; no node_rd and no in_ready during the stall; output sequence unchanged.
- total=0 start. Required: done=1 on the following cycle; in_ready and node_rd never asserted.
- Loop tree: node0 = {0x000, 0x000}, feed 0x00 bytes continuously. Required: error=1 after 256 internal steps; busy=0; char_valid never asserted; next start clears error.
- Reset mid-decode: rst_n pulsed low during WAITNODE of test 1. Required: all outputs 0 immediately; a fresh start then reproduces test 1 exactly.
